// File: rtl/flash_ctrl_pkg.sv
// Shared definitions for the flash page-read sequencer: FSM states, CSR offsets,
// default phase timing and CSR field positions.
package flash_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSense1,
    StSense2,
    StOe,
    StAck
  } state_e;

  localparam logic [7:0] PAGE_LO = 8'h00;
  localparam logic [7:0] PAGE_HI = 8'h1C;
  localparam logic [7:0] TIMING  = 8'h20;
  localparam logic [7:0] STATUS  = 8'h24;

  localparam logic [7:0] TSetupDef = 8'd4;
  localparam logic [7:0] TSen1Def  = 8'd8;
  localparam logic [7:0] TSen2Def  = 8'd8;
  localparam logic [7:0] TOeDef    = 8'd2;

  localparam int unsigned TimSetupLsb = 0;
  localparam int unsigned TimSen1Lsb  = 8;
  localparam int unsigned TimSen2Lsb  = 16;
  localparam int unsigned TimOeLsb    = 24;

  localparam int unsigned StatBusyBit = 0;
  localparam int unsigned StatPageLsb = 8;
  localparam int unsigned StatDataLsb = 16;

endpackage

// File: rtl/flash_phase_timer.sv
// Loadable 8-bit down-counter timing one sequencer phase; done_o marks the phase's last cycle.
module flash_phase_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] val_i,
  output logic       done_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = val_i;
    end else if (count_q > 8'd1) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // A loaded value of 0 is treated as a one-cycle phase.
  assign done_o = (count_q <= 8'd1);

endmodule

// File: rtl/flash_read_sequencer.sv
// Wishbone page reader for the 8x8 flash array: drives page select, two-stage sense and
// output enables, captures the sense-amp byte and returns it on the bus.
module flash_read_sequencer
  import flash_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [7:0]  T_SETUP_DEF = TSetupDef,
  parameter logic [7:0]  T_SEN1_DEF  = TSen1Def,
  parameter logic [7:0]  T_SEN2_DEF  = TSen2Def,
  parameter logic [7:0]  T_OE_DEF    = TOeDef
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [2:0]  page_sel,
  output logic        page_vld,
  output logic        sen1,
  output logic        sen2,
  output logic [3:0]  out_en,
  input  logic [7:0]  sa_out,
  output logic        done_irq
);

  state_e      state_q, state_d;
  logic [2:0]  page_q, page_d;
  logic [2:0]  last_page_q, last_page_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] timing_q, timing_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic        tmr_load;
  logic [7:0]  tmr_val;
  logic        tmr_done;

  logic        hit, req, is_page, is_timing, is_status, busy;
  logic [31:0] status;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
  assign is_page   = (wbs_adr_i[7:2] >= PAGE_LO[7:2]) && (wbs_adr_i[7:2] <= PAGE_HI[7:2]);
  assign is_timing = (wbs_adr_i[7:2] == TIMING[7:2]);
  assign is_status = (wbs_adr_i[7:2] == STATUS[7:2]);

  assign busy = (state_q == StSetup) || (state_q == StSense1) ||
                (state_q == StSense2) || (state_q == StOe);

  always_comb begin
    status = '0;
    status[StatBusyBit]             = busy;
    status[StatPageLsb +: 3]        = last_page_q;
    status[StatDataLsb +: 8]        = data_q;
  end

  // TIMING can only change from IDLE, so reading it live during a sequence is
  // equivalent to sampling it at acceptance.
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    last_page_d = last_page_q;
    data_d      = data_q;
    timing_d    = timing_q;
    ack_d       = 1'b0;
    dat_d       = '0;
    tmr_load    = 1'b0;
    tmr_val     = timing_q[TimSetupLsb +: 8];

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (is_page && !wbs_we_i) begin
            page_d   = wbs_adr_i[4:2];
            tmr_load = 1'b1;
            tmr_val  = timing_q[TimSetupLsb +: 8];
            state_d  = StSetup;
          end else begin
            ack_d = 1'b1;
            if (wbs_we_i) begin
              if (is_timing) begin
                for (int b = 0; b < 4; b++) begin
                  if (wbs_sel_i[b]) timing_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
                end
              end
            end else if (is_timing) begin
              dat_d = timing_q;
            end else if (is_status) begin
              dat_d = status;
            end
          end
        end
      end
      StSetup: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = timing_q[TimSen1Lsb +: 8];
          state_d  = StSense1;
        end
      end
      StSense1: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = timing_q[TimSen2Lsb +: 8];
          state_d  = StSense2;
        end
      end
      StSense2: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = timing_q[TimOeLsb +: 8];
          state_d  = StOe;
        end
      end
      StOe: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (tmr_done) begin
          data_d      = sa_out;
          last_page_d = page_q;
          ack_d       = 1'b1;
          dat_d       = {24'h0, sa_out};
          state_d     = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      page_q      <= 3'd0;
      last_page_q <= 3'd0;
      data_q      <= 8'h00;
      timing_q    <= {T_OE_DEF, T_SEN2_DEF, T_SEN1_DEF, T_SETUP_DEF};
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      last_page_q <= last_page_d;
      data_q      <= data_d;
      timing_q    <= timing_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  flash_phase_timer u_timer (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  assign page_vld  = busy;
  assign page_sel  = busy ? page_q : 3'd0;
  assign sen1      = (state_q == StSense1) || (state_q == StSense2) || (state_q == StOe);
  assign sen2      = (state_q == StSense2) || (state_q == StOe);
  assign out_en    = (state_q == StOe) ? 4'hF : 4'h0;
  assign done_irq  = (state_q == StAck);
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Directed plus randomized bench for flash_read_sequencer against a cycle-count model of
// the page-read phases and CSR map.
module tb_flash_read_sequencer;

  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] TIM_DEF = 32'h0208_0804;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic [2:0]  page_sel;
  logic        page_vld, sen1, sen2, done_irq;
  logic [3:0]  out_en;
  logic [7:0]  sa;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] tim_m;
  logic [2:0]  lp_m;
  logic [7:0]  ld_m;

  flash_read_sequencer dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .page_sel  (page_sel),
    .page_vld  (page_vld),
    .sen1      (sen1),
    .sen2      (sen2),
    .out_en    (out_en),
    .sa_out    (sa),
    .done_irq  (done_irq)
  );

  always #5 clk = ~clk;

  function automatic int eff(logic [7:0] t);
    return (t == 8'd0) ? 1 : int'(t);
  endfunction

  function automatic logic [31:0] ctl_exp(bit ack, bit irq, bit vld, bit s1, bit s2, bit oe,
                                          logic [2:0] pg);
    return {20'h0, ack, irq, vld, s1, s2, (oe ? 4'hF : 4'h0), pg};
  endfunction

  function automatic logic [31:0] ctl_obs();
    return {20'h0, wbs_ack_o, done_irq, page_vld, sen1, sen2, out_en, page_sel};
  endfunction

  function automatic logic [31:0] status_m();
    return {8'h00, ld_m, 5'h00, lp_m, 8'h00};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle CSR/other access: ack expected in cycle 1, never in cycles 0 or 2.
  task automatic csr(input bit w, input logic [7:0] off, input logic [31:0] wd,
                     input logic [3:0] sl, input logic [31:0] exp_rd, input string tag);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = BASE | {24'h0, off}; wdat = wd; sel = sl;
    @(negedge clk);
    check({tag, "/c0"}, ctl_obs(), 32'h0);
    @(negedge clk);
    check({tag, "/ack"}, ctl_obs(), ctl_exp(1, 0, 0, 0, 0, 0, 3'd0));
    check({tag, "/dat"}, wbs_dat_o, exp_rd);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    check({tag, "/c2"}, ctl_obs(), 32'h0);
  endtask

  // Page read; stop_at>0 drops cyc (or asserts reset) during that cycle.
  task automatic page_read(input logic [2:0] pg, input int stop_at, input bit stop_rst,
                           input string tag);
    int ts, t1, t2, toe, ack_at, last;
    logic [7:0]  cap;
    logic [31:0] exp;
    ts     = eff(tim_m[7:0]);
    t1     = eff(tim_m[15:8]);
    t2     = eff(tim_m[23:16]);
    toe    = eff(tim_m[31:24]);
    ack_at = ts + t1 + t2 + toe + 1;
    last   = (stop_at > 0) ? stop_at + 1 : ack_at;
    cap    = 8'h00;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = BASE | {27'h0, pg, 2'b00};
    sa = 8'($urandom);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == ack_at - 1) cap = sa;
      if (k == 0 || (stop_at > 0 && k == last)) exp = 32'h0;
      else if (k < ack_at) exp = ctl_exp(0, 0, 1, k > ts, k > ts + t1, k > ts + t1 + t2, pg);
      else exp = ctl_exp(1, 1, 0, 0, 0, 0, 3'd0);
      check({tag, "/ctl"}, ctl_obs(), exp);
      if (k == ack_at) check({tag, "/dat"}, wbs_dat_o, {24'h0, cap});
      if (stop_rst && k == last) check({tag, "/rstdat"}, wbs_dat_o, 32'h0);
      if (k < last) begin
        @(posedge clk); #1;
        sa = 8'($urandom);
        if (stop_at > 0 && k == stop_at - 1) begin
          if (stop_rst) rst = 1;
          else cyc = 0;
        end
      end
    end
    @(posedge clk); #1;
    cyc = 0; stb = 0; rst = 0;
    @(negedge clk);
    check({tag, "/after"}, ctl_obs(), 32'h0);
    if (stop_at == 0) begin
      lp_m = pg;
      ld_m = cap;
    end else if (stop_rst) begin
      tim_m = TIM_DEF;
      lp_m  = 3'd0;
      ld_m  = 8'h00;
    end
  endtask

  initial begin
    logic [31:0] wd;
    logic [3:0]  sl;
    rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0; sa = 0;
    tim_m = TIM_DEF; lp_m = 3'd0; ld_m = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/ctl", ctl_obs(), 32'h0);
    check("reset/dat", wbs_dat_o, 32'h0);
    @(posedge clk); #1;
    rst = 0;

    csr(0, 8'h20, 32'h0, 4'h0, tim_m, "tim_rd");
    csr(0, 8'h24, 32'h0, 4'h0, status_m(), "stat_rd");

    page_read(3'd5, 0, 0, "def_rd");
    csr(0, 8'h24, 32'h0, 4'h0, status_m(), "stat_def");

    csr(1, 8'h20, 32'h0, 4'b0011, 32'h0, "tim_wr");
    tim_m[15:0] = 16'h0;
    csr(0, 8'h20, 32'h0, 4'h0, tim_m, "tim_rd2");
    page_read(3'd0, 0, 0, "zero_rd");

    for (int i = 0; i < 10; i++) begin
      wd = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
            8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
      sl = 4'($urandom);
      csr(1, 8'h20, wd, sl, 32'h0, "rnd_tim");
      for (int b = 0; b < 4; b++) if (sl[b]) tim_m[8*b +: 8] = wd[8*b +: 8];
      page_read(3'($urandom), (i % 4 == 3) ? 2 : 0, 0, "rnd_rd");
      csr(0, 8'h24, 32'h0, 4'h0, status_m(), "rnd_stat");
    end

    csr(1, 8'h20, TIM_DEF, 4'hF, 32'h0, "tim_restore");
    tim_m = TIM_DEF;
    page_read(3'd6, 0, 0, "pre_abort");
    page_read(3'd3, 10, 0, "abort");
    csr(0, 8'h24, 32'h0, 4'h0, status_m(), "stat_abort");

    page_read(3'd2, 15, 1, "rst_sen2");
    csr(0, 8'h20, 32'h0, 4'h0, tim_m, "tim_after_rst");
    csr(0, 8'h24, 32'h0, 4'h0, status_m(), "stat_after_rst");

    page_read(3'd7, 0, 0, "post_rst_rd");
    csr(1, 8'h08, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr_page");
    csr(0, 8'h30, 32'h0, 4'h0, 32'h0, "rd_30");
    csr(1, 8'h24, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_stat");
    csr(0, 8'h24, 32'h0, 4'h0, status_m(), "stat_final");
    csr(0, 8'h20, 32'h0, 4'h0, tim_m, "tim_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
